piso_serial_tx: RTL
===================

Name: piso_serial_tx

Overview:
- Parallel-in, serial-out transmitter. It is the transmit end of the team's 8-bit serial-in shift-register receivers.
- Accepts parallel words over a valid/ready handshake and buffers one word in a holding register.
- Shifts each word out MSB-first with a frame strobe, optionally followed by a parity bit.
- Sits between a parallel producer (accumulator/multiplier datapath) and a serial link.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- GAP, 0, forced idle cycles (sout=1) between consecutive frames (0..15).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- din  in  WIDTH  parallel word to send
- din_valid  in  1  producer has a word on din
- din_ready  out  1  transmitter can accept a word this cycle
- sout  out  1  serial data, idle level 1
- sframe  out  1  high during the first data bit of each frame
- sbusy  out  1  high while a frame (data or parity bit) is on sout
- done  out  1  one-cycle pulse after the last bit of a frame

Behaviour:
- Only clk and reset are used; clk is the single clock. Reset is asynchronous and active-low.
- Reset values: sout=1, sframe=0, sbusy=0, done=0, hold_full=0, state=IDLE, bit counter=0, gap counter=0.
- din_ready is combinational: din_ready = ~hold_full. It is 1 after reset.
- Accept: at an edge where din_valid & din_ready, hold <= din and hold_full <= 1. din is ignored when not accepted. din_valid may drop without being accepted.
- FSM states: IDLE, SHIFT, PARITY (only with PARITY_EN), GAP.
- IDLE: sout=1, sbusy=0. If hold_full, at the next edge shreg <= hold, hold_full <= 0, bitcnt <= 0, go to SHIFT.
- SHIFT: sout = shreg[WIDTH-1], sbusy=1, sframe = (bitcnt==0). Each edge shifts shreg left, pads 0, and increments bitcnt.
- Leaving SHIFT at the edge where bitcnt==WIDTH-1:
  - to PARITY if enabled;
  - else to GAP if GAP>0;
  - else, if hold_full, reload immediately (back-to-back, no bubble);
  - else to IDLE.
- GAP: sout=1, sbusy=0 for exactly GAP cycles, then behaves as IDLE. The reload check happens at the last GAP edge.
- done is registered. It is high for exactly the one cycle following the final bit of a frame (data or parity).
- Latency: word accepted at edge N drives its first bit during the cycle after edge N+1. Last data bit is driven in the cycle after edge N+WIDTH. done is high in the cycle after edge N+WIDTH+1.
- Throughput with GAP=0 and din_valid held: one bit per cycle, continuous. din_ready re-asserts the cycle after each reload.
- Simultaneous accept and reload cannot occur, because din_ready=0 whenever hold_full=1.
- Reset mid-frame:
  - sout returns to 1 and sbusy/sframe/done drop asynchronously.
  - The partial frame and any held word are discarded.
  - Operation resumes cleanly after deassertion.

Optional Feature:
- Macro PIPO_TX_PARITY_EN.
- Defined: after the last data bit, the FSM enters PARITY for one cycle. sout = even parity (XOR of all WIDTH bits of the word), sbusy=1, sframe=0. Frame length is WIDTH+1, and done follows the parity bit.
- Undefined: the PARITY state and its logic are absent, and frame length is WIDTH.

Test Plan:
1. Hold reset=0 for 3 cycles, then release -> sout=1, din_ready=1, sbusy=0, sframe=0, done=0 throughout. Assert reset=0 mid-cycle -> outputs reach these values without a clock edge.
2. WIDTH=8, GAP=0, single word 8'hA5 accepted at edge N -> sout 1,0,1,0,0,1,0,1 in cycles N+1..N+8; sframe only in N+1; sbusy N+1..N+8; done only in N+9; sout=1 afterwards.
3. GAP=0, din_valid held high with 8'hFF then 8'h00 -> 16 contiguous bits: eight 1s then eight 0s, no idle cycle between; sframe at bit 1 and bit 9; done pulses after bits 8 and 16.
4. GAP=2, same two words 8'hF0, 8'h0F -> exactly two sout=1 cycles with sbusy=0 between frames; second frame bits 0,0,0,0,1,1,1,1.
5. Send 8'h3C with 8'h81 queued, pull reset=0 during the 4th bit -> sout=1 immediately, 8'h81 is never transmitted; after release, a new 8'h81 transmits as 1,0,0,0,0,0,0,1.
6. With PIPO_TX_PARITY_EN defined, send 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 (parity=1); send 8'h03 -> parity bit 0; done follows bit 9.

Source files
------------

// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out transmitter: one-word holding buffer, MSB-first shift, frame strobe.
// Optional even-parity bit after the data bits when PIPO_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module piso_serial_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sframe,
    output logic             sbusy,
    output logic             done
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
`ifdef PIPO_TX_PARITY_EN
        S_PARITY,
`endif
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [3:0]       gapcnt_q, gapcnt_d;
    logic             sout_q, sout_d;
    logic             sframe_q, sframe_d;
    logic             sbusy_q, sbusy_d;
    logic             done_q, done_d;
    logic             load, end_frame;
`ifdef PIPO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bitcnt_d    = bitcnt_q;
        gapcnt_d    = gapcnt_q;
        done_d      = 1'b0;
        load        = 1'b0;
        end_frame   = 1'b0;
`ifdef PIPO_TX_PARITY_EN
        par_d       = par_q;
`endif

        if (din_valid && !hold_full_q) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: load = hold_full_q;
            S_SHIFT: begin
                shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == BIT_LAST) begin
`ifdef PIPO_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    end_frame = 1'b1;
                    done_d    = 1'b1;
`endif
                end
            end
`ifdef PIPO_TX_PARITY_EN
            S_PARITY: begin
                end_frame = 1'b1;
                done_d    = 1'b1;
            end
`endif
            S_GAP: begin
                gapcnt_d = gapcnt_q + 1'b1;
                if (gapcnt_q == GAP_LAST) begin
                    if (hold_full_q) load = 1'b1;
                    else             state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // With no gap the next word goes out on the very next edge, giving a seamless bitstream.
        if (end_frame) begin
            if (GAP > 0) begin
                state_d  = S_GAP;
                gapcnt_d = 4'd0;
            end else if (hold_full_q) begin
                load = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (load) begin
            state_d     = S_SHIFT;
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
            bitcnt_d    = '0;
`ifdef PIPO_TX_PARITY_EN
            par_d       = ^hold_q;
`endif
        end

        // Line outputs are registered, so they are derived from the next state.
        sout_d   = 1'b1;
        sframe_d = 1'b0;
        sbusy_d  = 1'b0;
        case (state_d)
            S_SHIFT: begin
                sout_d   = shreg_d[WIDTH-1];
                sbusy_d  = 1'b1;
                sframe_d = (bitcnt_d == '0);
            end
`ifdef PIPO_TX_PARITY_EN
            S_PARITY: begin
                sout_d  = par_d;
                sbusy_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bitcnt_q    <= '0;
            gapcnt_q    <= '0;
            sout_q      <= 1'b1;
            sframe_q    <= 1'b0;
            sbusy_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef PIPO_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bitcnt_q    <= bitcnt_d;
            gapcnt_q    <= gapcnt_d;
            sout_q      <= sout_d;
            sframe_q    <= sframe_d;
            sbusy_q     <= sbusy_d;
            done_q      <= done_d;
`ifdef PIPO_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign din_ready = ~hold_full_q;
    assign sout      = sout_q;
    assign sframe    = sframe_q;
    assign sbusy     = sbusy_q;
    assign done      = done_q;
endmodule
